if_id_fetch: RTL and testbench

Instruction fetch stage and IF/ID pipeline register of the pipelined RISC-V core. It generates the fetch PC and drives a single-outstanding request/acknowledge port to instruction memory. It buffers a returned word when decode is stalled and presents a registered instruction plus PC to the decode stage, where the immediate generator and register file consume it. It also handles branch redirects (flush), including discarding an in-flight fetch.

---
 rtl/if_id_fetch.sv | 143 ++++++++++++++
 tb/tb_if_id_fetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch.sv
// Instruction fetch stage plus IF/ID pipeline register.
// Keeps one request in flight to instruction memory, parks a returned word
// while decode is stalled, and squashes wrong-path work on a branch redirect.
module if_id_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    // IDLE: not started; REQ: request outstanding at req_addr;
    // HOLD: word parked while decode stalls; DROP: wrong-path request still in flight.
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic [31:0] hold_pc, hold_pc_nxt;
    logic [31:0] hold_instr, hold_instr_nxt;
    logic [31:0] ifid_pc_nxt, ifid_instr_nxt;
    logic        ifid_valid_nxt;

    // A request is on the bus in REQ and DROP; it falls with the async reset.
    assign imem_req_o  = (state == REQ) || (state == DROP);
    // The bus address is its own register so a redirect cannot disturb a pending request.
    assign imem_addr_o = req_addr;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state, fetch PC, hold buffer and IF/ID next values.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and infers a latch.
        state_nxt      = state;
        pc_nxt         = pc;
        hold_pc_nxt    = hold_pc;
        hold_instr_nxt = hold_instr;
        ifid_pc_nxt    = pc_o;
        ifid_instr_nxt = instr_o;
        ifid_valid_nxt = valid_o;

        if (flush_i) begin
            // Redirect wins over stall: squash IF/ID, retarget the fetch PC.
            pc_nxt         = branch_target_i;
            ifid_instr_nxt = NOP_INSTR;
            ifid_valid_nxt = 1'b0;
            case (state)
                IDLE: if (start_i) state_nxt = REQ;
                REQ:  state_nxt = imem_ack_i ? REQ : DROP;
                HOLD: state_nxt = REQ;
                DROP: state_nxt = imem_ack_i ? REQ : DROP;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) state_nxt = REQ;
                    if (!stall_i) begin
                        ifid_instr_nxt = NOP_INSTR;
                        ifid_valid_nxt = 1'b0;
                    end
                end
                REQ: begin
                    if (imem_ack_i) begin
                        pc_nxt = pc + 32'd4;
                        if (stall_i) begin
                            hold_pc_nxt    = pc;
                            hold_instr_nxt = imem_data_i;
                            state_nxt      = HOLD;
                        end else begin
                            ifid_pc_nxt    = pc;
                            ifid_instr_nxt = imem_data_i;
                            ifid_valid_nxt = 1'b1;
                        end
                    end else if (!stall_i) begin
                        ifid_instr_nxt = NOP_INSTR;
                        ifid_valid_nxt = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        ifid_pc_nxt    = hold_pc;
                        ifid_instr_nxt = hold_instr;
                        ifid_valid_nxt = 1'b1;
                        state_nxt      = REQ;
                    end
                end
                DROP: begin
                    // pc already holds the redirect target; only the ack matters.
                    if (imem_ack_i) state_nxt = REQ;
                    if (!stall_i) begin
                        ifid_instr_nxt = NOP_INSTR;
                        ifid_valid_nxt = 1'b0;
                    end
                end
            endcase
        end

        // The bus address may only move once nothing is pending on it.
        req_addr_nxt = (imem_req_o && !imem_ack_i) ? req_addr : pc_nxt;
    end

    // Datapath registers: fetch PC, bus address, hold buffer, IF/ID.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            // NOTE: the hold buffer is only read after being written, but it is
            // two plain registers, so it is reset to keep state fully defined.
            hold_pc    <= 32'h0;
            hold_instr <= 32'h0;
            pc_o       <= 32'h0;
            instr_o    <= NOP_INSTR;
            valid_o    <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            req_addr   <= req_addr_nxt;
            hold_pc    <= hold_pc_nxt;
            hold_instr <= hold_instr_nxt;
            pc_o       <= ifid_pc_nxt;
            instr_o    <= ifid_instr_nxt;
            valid_o    <= ifid_valid_nxt;
        end
    end

endmodule

// File: tb/tb_if_id_fetch.sv
// Self-checking bench for if_id_fetch: a per-cycle vector table with expected
// bus and IF/ID values, plus a queue of words that must reach decode in order.
module tb_if_id_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;

    if_id_fetch dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .pc_o            (pc_o),
        .instr_o         (instr_o),
        .valid_o         (valid_o)
    );

    always #5 clk_i = ~clk_i;

    // ctl = {start, ack, stall, flush, deliver}; deliver marks an acked word
    // that must eventually be presented to decode.
    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] data;
        logic [31:0] target;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] data,
                                input logic [31:0] target, input logic exp_req,
                                input logic [31:0] exp_addr, input logic exp_valid,
                                input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        vec_t v;
        v.ctl       = ctl;
        v.data      = data;
        v.target    = target;
        v.exp_req   = exp_req;
        v.exp_addr  = exp_addr;
        v.exp_valid = exp_valid;
        v.exp_pc    = exp_pc;
        v.exp_instr = exp_instr;
        return v;
    endfunction

    // One clock: drive at negedge, check the bus before the edge, IF/ID after it.
    task automatic apply_vec(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk_i);
        start_i         = v.ctl[4];
        imem_ack_i      = v.ctl[3];
        stall_i         = v.ctl[2];
        flush_i         = v.ctl[1];
        imem_data_i     = v.data;
        branch_target_i = v.target;
        if (v.ctl[0]) sb.push_back('{pc: v.exp_addr, instr: v.data});
        #1;
        check({tag, " req"}, 32'(imem_req_o), 32'(v.exp_req));
        if (v.exp_req) check({tag, " addr"}, imem_addr_o, v.exp_addr);
        @(posedge clk_i);
        #1;
        check({tag, " valid"}, 32'(valid_o), 32'(v.exp_valid));
        check({tag, " pc_o"}, pc_o, v.exp_pc);
        check({tag, " instr"}, instr_o, v.exp_instr);
        // A fresh word reaches decode only on an unstalled, unflushed edge.
        if (!v.ctl[2] && !v.ctl[1] && valid_o) begin
            if (sb.size() == 0) begin
                check({tag, " sb_unexpected"}, 32'(valid_o), 32'h0);
            end else begin
                e = sb.pop_front();
                check({tag, " sb_pc"}, pc_o, e.pc);
                check({tag, " sb_instr"}, instr_o, e.instr);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; start_i = 1'b0; imem_ack_i = 1'b0; imem_data_i = '0;
        stall_i = 1'b0; flush_i = 1'b0; branch_target_i = '0;

        // Reset/start, zero-wait stream, stall on ack, flush cases.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(5'b00000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(5'b10000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, NOP));
        vecs.push_back(mk(5'b01001, 32'hA000_0000, 32'h0, 1'b1, 32'h0,   1'b1, 32'h0,   32'hA000_0000));
        vecs.push_back(mk(5'b01001, 32'hA000_0001, 32'h0, 1'b1, 32'h4,   1'b1, 32'h4,   32'hA000_0001));
        vecs.push_back(mk(5'b01001, 32'hA000_0002, 32'h0, 1'b1, 32'h8,   1'b1, 32'h8,   32'hA000_0002));
        vecs.push_back(mk(5'b01001, 32'hA000_0003, 32'h0, 1'b1, 32'hC,   1'b1, 32'hC,   32'hA000_0003));
        vecs.push_back(mk(5'b01101, 32'hB000_0000, 32'h0, 1'b1, 32'h10,  1'b1, 32'hC,   32'hA000_0003));
        vecs.push_back(mk(5'b00100, 32'h0, 32'h0, 1'b0, 32'h0,   1'b1, 32'hC,   32'hA000_0003));
        vecs.push_back(mk(5'b00100, 32'h0, 32'h0, 1'b0, 32'h0,   1'b1, 32'hC,   32'hA000_0003));
        vecs.push_back(mk(5'b00000, 32'h0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h10,  32'hB000_0000));
        vecs.push_back(mk(5'b00000, 32'h0, 32'h0, 1'b1, 32'h14,  1'b0, 32'h10,  NOP));
        vecs.push_back(mk(5'b00010, 32'h0, 32'h100, 1'b1, 32'h14, 1'b0, 32'h10, NOP));
        vecs.push_back(mk(5'b00000, 32'h0, 32'h0, 1'b1, 32'h14,  1'b0, 32'h10,  NOP));
        vecs.push_back(mk(5'b01000, DEAD,  32'h0, 1'b1, 32'h14,  1'b0, 32'h10,  NOP));
        vecs.push_back(mk(5'b01001, 32'hC000_0000, 32'h0, 1'b1, 32'h100, 1'b1, 32'h100, 32'hC000_0000));
        vecs.push_back(mk(5'b01100, 32'hC000_0001, 32'h0, 1'b1, 32'h104, 1'b1, 32'h100, 32'hC000_0000));
        vecs.push_back(mk(5'b00110, 32'h0, 32'h200, 1'b0, 32'h0, 1'b0, 32'h100, NOP));
        vecs.push_back(mk(5'b01001, 32'hC000_0002, 32'h0, 1'b1, 32'h200, 1'b1, 32'h200, 32'hC000_0002));
        vecs.push_back(mk(5'b01010, DEAD, 32'h300, 1'b1, 32'h204, 1'b0, 32'h200, NOP));
        vecs.push_back(mk(5'b00010, 32'h0, 32'h400, 1'b1, 32'h300, 1'b0, 32'h200, NOP));
        vecs.push_back(mk(5'b01010, DEAD, 32'h500, 1'b1, 32'h300, 1'b0, 32'h200, NOP));
        vecs.push_back(mk(5'b01001, 32'hD000_0000, 32'h0, 1'b1, 32'h500, 1'b1, 32'h500, 32'hD000_0000));
        vecs.push_back(mk(5'b00100, 32'h0, 32'h0, 1'b1, 32'h504, 1'b1, 32'h500, 32'hD000_0000));
        vecs.push_back(mk(5'b00000, 32'h0, 32'h0, 1'b1, 32'h504, 1'b0, 32'h500, NOP));

        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i], $sformatf("v%0d", i));

        // PC wrap: redirect to the last word, then the next request is at 0.
        apply_vec(mk(5'b01010, DEAD, 32'hFFFF_FFFC, 1'b1, 32'h504, 1'b0, 32'h500, NOP), "wrap0");
        apply_vec(mk(5'b01001, 32'hE000_0000, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'hE000_0000), "wrap1");
        apply_vec(mk(5'b00000, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 32'hFFFF_FFFC, NOP), "wrap2");

        // Async reset while a request is pending: outputs clear with no clock edge.
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("async_rst req",   32'(imem_req_o), 32'h0);
        check("async_rst valid", 32'(valid_o),    32'h0);
        check("async_rst pc_o",  pc_o,            32'h0);
        check("async_rst instr", instr_o,         NOP);
        @(negedge clk_i);
        rst_i = 1'b1;

        // A stray ack in IDLE is ignored.
        apply_vec(mk(5'b01000, DEAD, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, NOP), "idle_ack0");
        apply_vec(mk(5'b01000, DEAD, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, NOP), "idle_ack1");

        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
